// File: rtl/wb_regfile.sv
// Writeback stage: EX/WB pipeline register, 8x8 register file with write-through
// read bypass, and a retired-instruction counter.
module wb_regfile #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [7:0]       EX_Instr,
  input  logic [7:0]       EX_ALUOut,
  input  logic [2:0]       rdA_addr,
  input  logic [2:0]       rdB_addr,
  output logic [7:0]       A,
  output logic [7:0]       B,
  output logic [2:0]       EX_WB_Dst,
  output logic [7:0]       EX_WB_ALUOut,
  output logic             EX_WB_Valid,
  output logic [CNT_W-1:0] retired
);

  logic             valid_q, valid_d;
  logic [2:0]       dst_q, dst_d;
  logic [7:0]       alu_q, alu_d;
  logic [7:0]       regs_q [NREGS];
  logic [7:0]       regs_d [NREGS];
  logic [CNT_W-1:0] retired_q, retired_d;

  logic wb_en;
  logic wb_advance;

  assign wb_en      = ~EX_Instr[7];
  assign wb_advance = ~stall | flush;

  // Only the write-enable and destination fields are decoded here.
  logic unused_instr;
  assign unused_instr = ^{EX_Instr[6], EX_Instr[2:0]};

  always_comb begin
    valid_d   = valid_q;
    dst_d     = dst_q;
    alu_d     = alu_q;
    regs_d    = regs_q;
    retired_d = retired_q;

    // Commit is independent of stall; a held WB instruction rewrites the same value.
    if (valid_q) begin
      regs_d[dst_q] = alu_q;
      if (wb_advance) begin
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end

    // Bubbles keep dst/alu so the forwarding bus never carries a value not in the array.
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = wb_en;
      if (wb_en) begin
        dst_d = EX_Instr[5:3];
        alu_d = EX_ALUOut;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      dst_q     <= '0;
      alu_q     <= '0;
      retired_q <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      dst_q     <= dst_d;
      alu_q     <= alu_d;
      retired_q <= retired_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    A = (valid_q && (dst_q == rdA_addr)) ? alu_q : regs_q[rdA_addr];
    B = (valid_q && (dst_q == rdB_addr)) ? alu_q : regs_q[rdB_addr];
  end

  assign EX_WB_Valid  = valid_q;
  assign EX_WB_Dst    = dst_q;
  assign EX_WB_ALUOut = alu_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed scenarios then randomized traffic, checked
// against a transaction-level model of the writeback stage.
module tb_wb_regfile;

  localparam int CW = 6;  // narrow counter so random traffic exercises the wrap

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [7:0]    ex_instr = 8'h00;
  logic [7:0]    ex_aluout = 8'h00;
  logic [2:0]    rda = 3'd0;
  logic [2:0]    rdb = 3'd0;
  logic [7:0]    a_o, b_o, wb_alu;
  logic [2:0]    wb_dst;
  logic          wb_valid;
  logic [CW-1:0] retired;

  wb_regfile #(.NREGS(8), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .EX_Instr     (ex_instr),
    .EX_ALUOut    (ex_aluout),
    .rdA_addr     (rda),
    .rdB_addr     (rdb),
    .A            (a_o),
    .B            (b_o),
    .EX_WB_Dst    (wb_dst),
    .EX_WB_ALUOut (wb_alu),
    .EX_WB_Valid  (wb_valid),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [2:0]    d;
    logic [7:0]    o;
    logic [7:0]    a;
    logic [7:0]    b;
    logic [CW-1:0] r;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: architectural registers, the instruction sitting in WB, retire count.
  int m_regs [8];
  bit m_v;
  int m_d;
  int m_o;
  int m_ret;

  function automatic int m_read(input int addr);
    if (m_v && m_d == addr) return m_o;
    return m_regs[addr];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_v   = 1'b0;
    m_d   = 0;
    m_o   = 0;
    m_ret = 0;
  endtask

  task automatic drive(input bit r, input bit s, input bit f, input logic [7:0] ins,
                       input logic [7:0] alu, input logic [2:0] ra, input logic [2:0] rb);
    exp_t e;
    bit   writes;
    @(posedge clk);
    #1;
    rst = r; stall = s; flush = f; ex_instr = ins; ex_aluout = alu; rda = ra; rdb = rb;
    e.v = m_v;
    e.d = 3'(m_d);
    e.o = 8'(m_o);
    e.a = 8'(m_read(int'(ra)));
    e.b = 8'(m_read(int'(rb)));
    e.r = CW'(m_ret);
    q.push_back(e);
    if (r) begin
      m_reset();
    end else begin
      if (m_v) begin
        m_regs[m_d] = m_o;
        if (!s || f) m_ret = (m_ret + 1) % (1 << CW);
      end
      if (!s || f) begin
        writes = !f && (ins[7] == 1'b0);
        if (writes) begin
          m_d = int'(ins[5:3]);
          m_o = int'(alu);
        end
        m_v = writes;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid",   16'(wb_valid), 16'(e.v));
        chk("dst",     16'(wb_dst),   16'(e.d));
        chk("aluout",  16'(wb_alu),   16'(e.o));
        chk("read_a",  16'(a_o),      16'(e.a));
        chk("read_b",  16'(b_o),      16'(e.b));
        chk("retired", 16'(retired),  16'(e.r));
      end
    end
  end

  initial begin
    m_reset();
    // Reset held two cycles with a writing instruction present, then sweep all addresses.
    drive(1, 0, 0, 8'h28, 8'hAA, 3'd0, 3'd4);
    drive(1, 0, 0, 8'h28, 8'hAA, 3'd1, 3'd5);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 8'h80, 8'h00, 3'(i), 3'(i + 4));
    // Basic commit to r5 then read via bypass and array.
    drive(0, 0, 0, 8'h28, 8'h3C, 3'd5, 3'd0);
    drive(0, 0, 0, 8'h80, 8'h00, 3'd5, 3'd5);
    drive(0, 0, 0, 8'h80, 8'h00, 3'd5, 3'd3);
    // Non-writing instruction aimed at r3.
    drive(0, 0, 0, 8'h9D, 8'hFF, 3'd3, 3'd5);
    drive(0, 0, 0, 8'h80, 8'h00, 3'd3, 3'd5);
    // Commit r2 then stall three cycles with a different r2 value waiting in EX.
    drive(0, 0, 0, 8'h10, 8'h11, 3'd2, 3'd2);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 8'h10, 8'h22, 3'd2, 3'd2);
    drive(0, 0, 0, 8'h80, 8'h00, 3'd2, 3'd2);
    drive(0, 0, 0, 8'h80, 8'h00, 3'd2, 3'd2);
    // Flush and stall together with an r7 write in EX.
    drive(0, 1, 1, 8'h38, 8'h77, 3'd7, 3'd7);
    drive(0, 0, 0, 8'h80, 8'h00, 3'd7, 3'd7);
    drive(0, 0, 0, 8'h80, 8'h00, 3'd7, 3'd7);
    // Back-to-back writes to r4.
    drive(0, 0, 0, 8'h20, 8'h01, 3'd0, 3'd4);
    drive(0, 0, 0, 8'h20, 8'h02, 3'd0, 3'd4);
    drive(0, 0, 0, 8'h80, 8'h00, 3'd0, 3'd4);
    drive(0, 0, 0, 8'h80, 8'h00, 3'd0, 3'd4);
    drive(0, 0, 0, 8'h80, 8'h00, 3'd0, 3'd4);
    // Reset arriving while an r1 write sits in WB.
    drive(0, 0, 0, 8'h08, 8'h5A, 3'd1, 3'd4);
    drive(1, 0, 0, 8'h08, 8'h66, 3'd1, 3'd4);
    drive(0, 0, 0, 8'h80, 8'h00, 3'd1, 3'd5);
    drive(0, 0, 0, 8'h08, 8'h99, 3'd1, 3'd5);
    drive(0, 0, 0, 8'h80, 8'h00, 3'd1, 3'd5);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 8, 8'($urandom), 8'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage of the 8-bit pipelined processor: the EX/WB pipeline register plus the 8×8 register file it commits into. It produces `EX_WB_Dst`/`EX_WB_ALUOut`, the result bus the forwarding unit consumes. It also supplies the operand values `A`/`B` that the forwarding unit either passes through or overrides. The block keeps a retired-instruction counter for debug and performance visibility.

## Interface
- `NREGS`, 8: register count. Fixed; address width is 3.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold the EX/WB register this cycle.
- `flush`  in  1  load a bubble into EX/WB this cycle. Has priority over `stall`.
- `EX_Instr`  in  8  instruction currently in EX.
- `EX_ALUOut`  in  8  ALU result of that instruction.
- `rdA_addr`  in  3  register-file read address, port A.
- `rdB_addr`  in  3  register-file read address, port B.
- `A`  out  8  port-A read data (combinational).
- `B`  out  8  port-B read data (combinational).
- `EX_WB_Dst`  out  3  destination register of the instruction in WB.
- `EX_WB_ALUOut`  out  8  result of the instruction in WB.
- `EX_WB_Valid`  out  1  WB holds a committing instruction.
- `retired`  out  CNT_W  count of committed writes.

## Operation
- Writeback decode from `EX_Instr`:
  - `wb_en = ~EX_Instr[7]`.
  - Destination is `EX_Instr[5:3]`.
  - Instructions with bit 7 set never write and never forward.
- EX/WB register update at posedge `clk`, highest priority first:
  - `rst`: `EX_WB_Valid=0`, `EX_WB_Dst=0`, `EX_WB_ALUOut=0`, all 8 registers = 0x00, `retired=0`.
  - `flush`: `EX_WB_Valid=0`. `EX_WB_Dst` and `EX_WB_ALUOut` hold.
  - `stall`: all EX/WB fields hold.
  - Otherwise, if `wb_en`: `EX_WB_Valid=1`, `EX_WB_Dst=EX_Instr[5:3]`, `EX_WB_ALUOut=EX_ALUOut`.
  - Otherwise (`wb_en=0`): bubble, handled the same as `flush`.
- Bubble rule: `Dst` and `ALUOut` always hold the last committed pair. That pair already equals the register-file contents, so the forwarding unit (which has no valid input) can never forward a stale or wrong value.
- Register-file commit: at posedge, if `EX_WB_Valid && !rst`, write `regs[EX_WB_Dst] <= EX_WB_ALUOut`.
  - This is independent of `stall`.
  - A stalled WB instruction rewrites the same value each cycle, which is idempotent.
- Retire counter:
  - Increments on a commit only when WB is advancing (`!stall || flush`), so each instruction counts once.
  - Wraps modulo 2^CNT_W.
- Read ports, port A (port B identical with `rdB_addr`):
  - If `EX_WB_Valid && EX_WB_Dst==rdA_addr`, `A = EX_WB_ALUOut` (write-through bypass).
  - Otherwise `A = regs[rdA_addr]`.
- Register r0 is an ordinary writable register.

## Timing
- EX→WB latency: 1 cycle.
- WB→register file: the write lands at the same edge that advances WB.
- Instruction N's result is visible:
  - on `EX_WB_*` in cycle N+1;
  - on `A`/`B` in cycle N+1 via the bypass;
  - from the array from cycle N+2.
- `A`/`B` are purely combinational from the addresses, `EX_WB_*` and the array. No internal read latency.
- Simultaneous `flush` and `stall`: flush wins, and WB becomes a bubble.
- `rst` asserted mid-stream discards the WB instruction. No write occurs at the reset edge.
- First cycle after `rst` deasserts:
  - all reads return 0x00;
  - `EX_WB_Valid=0`;
  - the first enabled instruction is captured at the next edge.
- Back-to-back writes to the same register: the later one wins. The bypass always reflects the WB instruction.

## Test plan
- Reset: hold `rst` 2 cycles with `EX_Instr=0x28`, `EX_ALUOut=0xAA` → `EX_WB_Valid=0`, `Dst=0`, `ALUOut=0`, A/B=0x00 for all addresses, `retired=0`.
- Basic commit: `EX_Instr=0x28` (dst r5), `EX_ALUOut=0x3C`, `rdA_addr=5`:
  - next cycle `Dst=5`, `ALUOut=0x3C`, `Valid=1`, A=0x3C (bypass);
  - after a following bubble, A=0x3C from the array;
  - `retired=1`.
- Non-writing instruction: `EX_Instr=0x9D`, `EX_ALUOut=0xFF` → `Valid=0`, `Dst`/`ALUOut` keep the prior 5/0x3C, r3 unchanged, `retired` unchanged.
- Stall: commit r2=0x11, then hold `stall` 3 cycles with `EX_Instr` targeting r2 and value 0x22 → `Dst`/`ALUOut` stay 2/0x11, r2=0x11, `retired` +1 only.
- Flush+stall together with `EX_Instr` targeting r7 and value 0x77 → `Valid=0`, r7 unchanged, `Dst`/`ALUOut` unchanged.
- Back-to-back r4=0x01 then r4=0x02 with `rdB_addr=4`: B=0x01, then 0x02, then 0x02 held; `retired` +2.
